// File: rtl/vga_scanout_reader_if.sv
// Frame-buffer read port: the scanout reader (master) drives address/strobe,
// the pixel RAM (slave) returns colour words a fixed latency later.
interface vga_scanout_reader_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 9
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_data
    );
endinterface

// File: rtl/vga_scanout_reader.sv
// VGA scanout reader: 640x480 timing, 4x4-replicated frame-buffer reads and
// colour expansion to the DAC, with sync/blank delayed to match RAM latency.
module vga_scanout_reader #(
    parameter int unsigned H_ACTIVE                = 640,
    parameter int unsigned H_FP                    = 16,
    parameter int unsigned H_SYNC                  = 96,
    parameter int unsigned H_BP                    = 48,
    parameter int unsigned V_ACTIVE                = 480,
    parameter int unsigned V_FP                    = 10,
    parameter int unsigned V_SYNC                  = 2,
    parameter int unsigned V_BP                    = 33,
    parameter int unsigned SCALE_SHIFT             = 2,
    parameter int unsigned ADDR_W                  = 15,
    parameter int unsigned MEM_LATENCY             = 1,
    parameter int unsigned BITS_PER_COLOUR_CHANNEL = 3
) (
    input  logic                 CLOCK_25,
    input  logic                 resetn,
    vga_scanout_reader_if.master mem,
    output logic [9:0]           VGA_R,
    output logic [9:0]           VGA_G,
    output logic [9:0]           VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK,
    output logic                 VGA_SYNC,
    output logic [9:0]           x_coordinate,
    output logic [8:0]           y_coordinate,
    output logic                 image_on,
    output logic                 frame_start
);
    localparam int unsigned BPC       = BITS_PER_COLOUR_CHANNEL;
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W       = $clog2(H_TOTAL);
    localparam int unsigned V_W       = $clog2(V_TOTAL);
    localparam int unsigned PIPE      = MEM_LATENCY + 2;
    localparam int unsigned ROW_WORDS = H_ACTIVE >> SCALE_SHIFT;

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_MASK   = V_W'((1 << SCALE_SHIFT) - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    state_e              state_q, state_d;
    logic [H_W-1:0]      h_q, h_d;
    logic [V_W-1:0]      v_q, v_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_en_q, rd_en_d;
    logic                image_on_q, image_on_d;
    logic                frame_start_q, frame_start_d;
    sync_t [PIPE-1:0]    sync_q, sync_d;
    logic [9:0]          r_q, r_d;
    logic [9:0]          g_q, g_d;
    logic [9:0]          b_q, b_d;
    logic                active_c;

    // Repeat the channel bits MSB-first until all 10 DAC bits are filled.
    function automatic logic [9:0] expand(input logic [BPC-1:0] c);
        logic [9:0] o;
        o = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            o[9-i] = c[BPC-1-(i % BPC)];
        end
        return o;
    endfunction

    assign active_c = (state_q == ST_RUN) && (h_q < H_ACT) && (v_q < V_ACT);

    // Scan counters and row base; first edge after reset parks the scan at (0,0).
    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        row_base_d    = row_base_q;
        if (state_q == ST_IDLE) begin
            state_d    = ST_RUN;
            h_d        = '0;
            v_d        = '0;
            row_base_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            if ((v_q < V_ACT) && ((v_q & V_MASK) == V_MASK)) begin
                row_base_d = row_base_q + ADDR_W'(ROW_WORDS);
            end
            if (v_q == V_LAST) begin
                v_d        = '0;
                row_base_d = '0;
            end else begin
                v_d = v_q + V_W'(1);
            end
        end else begin
            h_d = h_q + H_W'(1);
        end
        image_on_d    = (h_d < H_ACT) && (v_d < V_ACT);
        frame_start_d = (h_d == '0) && (v_d == '0);
    end

    // Read address one cycle behind the counters; held outside the active area.
    always_comb begin
        rd_en_d = active_c;
        addr_d  = addr_q;
        if (active_c) begin
            addr_d = row_base_q + ADDR_W'(h_q >> SCALE_SHIFT);
        end
    end

    // Sync/blank delay line; colour stage sees the blank bit aligned with mem_data.
    always_comb begin
        sync_d = sync_q;
        if (state_q == ST_RUN) begin
            sync_d[0].hs    = !((h_q >= HS_START) && (h_q < HS_END));
            sync_d[0].vs    = !((v_q >= VS_START) && (v_q < VS_END));
            sync_d[0].blank = (h_q < H_ACT) && (v_q < V_ACT);
        end else begin
            sync_d[0] = SYNC_IDLE;
        end
        for (int unsigned k = 1; k < PIPE; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (sync_q[PIPE-2].blank) begin
            r_d = expand(mem.mem_data[3*BPC-1 -: BPC]);
            g_d = expand(mem.mem_data[2*BPC-1 -: BPC]);
            b_d = expand(mem.mem_data[BPC-1:0]);
        end
    end

    always_ff @(posedge CLOCK_25 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            h_q           <= '0;
            v_q           <= '0;
            row_base_q    <= '0;
            addr_q        <= '0;
            rd_en_q       <= 1'b0;
            image_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
            for (int unsigned k = 0; k < PIPE; k++) begin
                sync_q[k] <= SYNC_IDLE;
            end
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            row_base_q    <= row_base_d;
            addr_q        <= addr_d;
            rd_en_q       <= rd_en_d;
            image_on_q    <= image_on_d;
            frame_start_q <= frame_start_d;
            sync_q        <= sync_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_rd_en = rd_en_q;
    assign VGA_R         = r_q;
    assign VGA_G         = g_q;
    assign VGA_B         = b_q;
    assign VGA_HS        = sync_q[PIPE-1].hs;
    assign VGA_VS        = sync_q[PIPE-1].vs;
    assign VGA_BLANK     = sync_q[PIPE-1].blank;
    assign VGA_SYNC      = 1'b0;
    assign x_coordinate  = 10'(h_q);
    assign y_coordinate  = 9'(v_q);
    assign image_on      = image_on_q;
    assign frame_start   = frame_start_q;
endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader: full-size and shrunken timings at RAM latency 1 and 3,
// checked every cycle against a frame-arithmetic model plus hand-computed pixels.
`timescale 1ns/1ps
module tb_vga_scanout_reader;
    localparam int unsigned AW = 15;
    localparam logic [8:0]  CONST_COLOUR = 9'b101_000_111;
    // {sync, hs, vs, blank, r, g, b, rd_en, addr, x, y, image_on, frame_start}
    localparam logic [70:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 30'd0, 1'b0, 15'd0,
                                         10'd0, 9'd0, 1'b1, 1'b0};

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        data_mode = 1'b0;
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          phase     = 0;
    int          hs_low [2] = '{0, 0};
    int          vs_low [2] = '{0, 0};
    logic [70:0] obs [4];
    logic [AW-1:0] model_addr [4];

    always #5 clk = ~clk;

    function automatic logic [8:0] ram_f(input logic [AW-1:0] a, input logic m);
        return m ? CONST_COLOUR : a[8:0];
    endfunction

    // Instances 0/1: 640x480 at latency 1/3; instances 2/3: 32x24 frame at latency 1/3.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam bit          SMALL = (gi >= 2);
        localparam int unsigned LAT   = (gi % 2 == 0) ? 1 : 3;
        logic [9:0]    r, g, b, x;
        logic [8:0]    y;
        logic          hs, vs, blank, sync, on, fs;
        logic [AW-1:0] ap [3];

        vga_scanout_reader_if #(.ADDR_W(AW), .DATA_W(9)) mif ();

        vga_scanout_reader #(
            .H_ACTIVE(SMALL ? 32 : 640), .H_FP(SMALL ? 4 : 16),
            .H_SYNC(SMALL ? 8 : 96),     .H_BP(SMALL ? 4 : 48),
            .V_ACTIVE(SMALL ? 24 : 480), .V_FP(SMALL ? 2 : 10),
            .V_SYNC(2),                  .V_BP(SMALL ? 2 : 33),
            .SCALE_SHIFT(2), .ADDR_W(AW), .MEM_LATENCY(LAT),
            .BITS_PER_COLOUR_CHANNEL(3)
        ) dut (
            .CLOCK_25(clk), .resetn(rst_n), .mem(mif),
            .VGA_R(r), .VGA_G(g), .VGA_B(b),
            .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK(blank), .VGA_SYNC(sync),
            .x_coordinate(x), .y_coordinate(y), .image_on(on), .frame_start(fs)
        );

        always @(posedge clk) begin
            ap[0] <= mif.mem_addr;
            ap[1] <= ap[0];
            ap[2] <= ap[1];
        end
        assign mif.mem_data = ram_f(ap[LAT-1], data_mode);
        assign obs[gi] = {sync, hs, vs, blank, r, g, b, mif.mem_rd_en, mif.mem_addr, x, y, on, fs};
    end

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void cfg(input int idx, output int ha, output int hf, output int hs,
                                output int va, output int vf, output int vs,
                                output int ht, output int vt, output int lat);
        if (idx >= 2) begin
            ha = 32;  hf = 4;  hs = 8;  ht = 48;
            va = 24;  vf = 2;  vs = 2;  vt = 30;
        end else begin
            ha = 640; hf = 16; hs = 96; ht = 800;
            va = 480; vf = 10; vs = 2;  vt = 525;
        end
        lat = (idx % 2 == 0) ? 1 : 3;
    endfunction

    // Pixel k of the scan (cycles since scan start): is it visible, and its RAM word.
    function automatic void pix(input int idx, input int k, output logic act, output int addr);
        int ha, hf, hs, va, vf, vs, ht, vt, lat, h, v;
        cfg(idx, ha, hf, hs, va, vf, vs, ht, vt, lat);
        h    = k % ht;
        v    = (k / ht) % vt;
        act  = (h < ha) && (v < va);
        addr = (v / 4) * (ha / 4) + (h / 4);
    endfunction

    function automatic logic [9:0] exp3(input logic [2:0] c);
        return {c, c, c, c[2]};
    endfunction

    function automatic logic [70:0] model(input int idx, input int n, input logic m,
                                          input logic [AW-1:0] maddr);
        int ha, hf, hs, va, vf, vs, ht, vt, lat, h, v, p, hp, vp, a;
        logic ehs, evs, eblank, erd, act;
        logic [8:0]  d;
        logic [29:0] rgb;
        cfg(idx, ha, hf, hs, va, vf, vs, ht, vt, lat);
        h      = n % ht;
        v      = (n / ht) % vt;
        ehs    = 1'b1;
        evs    = 1'b1;
        eblank = 1'b0;
        rgb    = '0;
        p      = n - (lat + 2);
        if (p >= 0) begin
            hp  = p % ht;
            vp  = (p / ht) % vt;
            ehs = !((hp >= ha + hf) && (hp < ha + hf + hs));
            evs = !((vp >= va + vf) && (vp < va + vf + vs));
            pix(idx, p, act, a);
            eblank = act;
            if (act) begin
                d   = m ? CONST_COLOUR : 9'(a);
                rgb = {exp3(d[8:6]), exp3(d[5:3]), exp3(d[2:0])};
            end
        end
        erd = 1'b0;
        if (n >= 1) pix(idx, n - 1, erd, a);
        return {1'b0, ehs, evs, eblank, rgb, erd, maddr, 10'(h), 9'(v),
                (h < ha) && (v < va), (h == 0) && (v == 0)};
    endfunction

    // Per-cycle compare against the model, plus hand-computed pins.
    always @(posedge clk) begin
        logic        act;
        int          a;
        int          pp;
        logic [70:0] e;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                model_addr[i] = '0;
                e = RESET_VEC;
            end else begin
                if (cyc >= 1) begin
                    pix(i, cyc - 1, act, a);
                    if (act) model_addr[i] = AW'(a);
                end
                e = model(i, cyc, data_mode, model_addr[i]);
            end
            chk($sformatf("scan_vec[%0d] cyc %0d", i, cyc), obs[i], e);
        end
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pp = (i % 2 == 0) ? 3 : 5;
                if (cyc == 0) chk($sformatf("frame_start_first_edge[%0d]", i), 71'(obs[i][0]), 71'(1));
                if (cyc == 1) chk($sformatf("first_read_addr0[%0d]", i), 71'(obs[i][36:21]), 71'({1'b1, 15'd0}));
                if (phase == 0 && i < 2) begin
                    if (cyc == 655 + pp) chk($sformatf("hs_before_fall[%0d]", i), 71'(obs[i][69]), 71'(1));
                    if (cyc == 656 + pp) chk($sformatf("hs_first_fall[%0d]", i), 71'(obs[i][69]), 71'(0));
                    if (cyc >= 800 + pp && cyc < 1600 + pp && !obs[i][69]) hs_low[i]++;
                    if (cyc == 1600 + pp) chk($sformatf("hs_low_per_line[%0d]", i), 71'(hs_low[i]), 71'(96));
                    if (cyc == 2403 + pp) chk($sformatf("pixel_3_3[%0d]", i), 71'(obs[i][67:37]), 71'({1'b1, 30'd0}));
                    if (cyc == 3205) chk($sformatf("pixel_4_4_addr[%0d]", i), 71'(obs[i][35:21]), 71'(161));
                    if (cyc == 3204 + pp) chk($sformatf("pixel_4_4_rgb[%0d]", i), 71'(obs[i][66:37]),
                                              71'({10'h124, 10'h249, 10'h092}));
                    if (cyc == 6500 + pp) chk($sformatf("const_rgb[%0d]", i), 71'(obs[i][66:37]),
                                              71'({10'h2DB, 10'h000, 10'h3FF}));
                    if (cyc == 7100 + pp) chk($sformatf("blank_rgb[%0d]", i), 71'(obs[i][67:37]), 71'(0));
                    if (cyc == 7101) chk($sformatf("blank_no_read[%0d]", i), 71'(obs[i][36]), 71'(0));
                end
                if (phase == 0 && i >= 2) begin
                    if (cyc == 1136) chk($sformatf("max_addr[%0d]", i), 71'(obs[i][36:21]), 71'({1'b1, 15'd47}));
                    if (cyc >= 1440 + pp && cyc < 2880 + pp && !obs[i][68]) vs_low[i-2]++;
                    if (cyc == 2880 + pp) chk($sformatf("vs_low_per_frame[%0d]", i), 71'(vs_low[i-2]), 71'(96));
                end
            end
            cyc++;
        end else begin
            cyc = 0;
        end
    end

    initial begin
        bit found;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (5000) @(negedge clk);
        data_mode = 1'b1;
        repeat (4700) @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (obs[2][20:11] == 10'd30 && obs[2][10:2] == 9'd13) found = 1'b1;
        end
        chk("midframe_reset_point", 71'(found), 71'(1));
        phase = 1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1500) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
